// File: rtl/gen_emu_clks_pkg.sv
// Shared types for the emulation clock generator: control FSM states and
// per-channel clock source modes.
package gen_emu_clks_pkg;

  typedef enum logic [1:0] {
    RUN,
    PAUSED,
    STEP
  } emu_state_t;

  typedef enum logic {
    MODE_DIRECT,
    MODE_DIV
  } chan_mode_t;

endpackage

// File: rtl/emu_clk_chan.sv
// One derived clock channel: either samples an external level or self-divides,
// advancing only on emu_clk rise edges.
module emu_clk_chan
  import gen_emu_clks_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             emu_clk_2x,
  input  logic             emu_rst_n,
  input  logic             rise_en,
  input  chan_mode_t       mode,
  input  logic             clk_val,
  input  logic [DIV_W-1:0] div_ratio,
  output logic             clk_out
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] last_cnt;

  // A ratio of 0 behaves like 1, so the terminal count is ratio-1 clamped at 0.
  assign last_cnt = (div_ratio == '0) ? '0 : div_ratio - DIV_W'(1);

  // The counter sits at 0 in direct mode, so a switch to divider mode starts
  // a fresh half-period; >= lets a shrinking ratio toggle on the next rise.
  always_ff @(posedge emu_clk_2x or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      clk_out <= 1'b0;
      cnt     <= '0;
    end else if (rise_en) begin
      if (mode == MODE_DIRECT) begin
        clk_out <= clk_val;
        cnt     <= '0;
      end else if (cnt >= last_cnt) begin
        clk_out <= ~clk_out;
        cnt     <= '0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/gen_emu_clks_ctrl.sv
// Emulation clock generator with run/pause/single-step control.
// Define EMU_CLK_BUFG_EN to route emu_clk and clks through BUFG primitives.
module gen_emu_clks_ctrl
  import gen_emu_clks_pkg::*;
#(
  parameter int n     = 2,
  parameter int DIV_W = 8,
  parameter int CNT_W = 32
) (
  input  logic                    emu_clk_2x,
  input  logic                    emu_rst_n,
  output logic                    emu_clk,
  input  logic                    pause_req,
  output logic                    pause_ack,
  input  logic                    step_req,
  input  logic [n-1:0]            clk_vals,
  input  logic [n-1:0]            chan_mode,
  input  logic [n-1:0][DIV_W-1:0] div_ratio,
  output logic [n-1:0]            clks,
  output logic [CNT_W-1:0]        emu_cycle_cnt
);

  emu_state_t     state;
  emu_state_t     state_nxt;
  logic           ph;
  logic           advance;
  logic           rise;
  logic [n-1:0]   clks_q;

  always_ff @(posedge emu_clk_2x or negedge emu_rst_n) begin
    if (!emu_rst_n) state <= RUN;
    else            state <= state_nxt;
  end

  // Pausing waits for ph==0 so emu_clk is never frozen high; a step ends
  // on the edge that brings ph back to 0.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (pause_req && !ph) state_nxt = PAUSED;
      PAUSED:  if (step_req) state_nxt = STEP;
               else if (!pause_req) state_nxt = RUN;
      STEP:    if (ph) state_nxt = pause_req ? PAUSED : RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    advance   = 1'b0;
    pause_ack = 1'b0;
    unique case (state)
      RUN:     advance = !(pause_req && !ph);
      PAUSED:  pause_ack = 1'b1;
      STEP:    advance = 1'b1;
      default: advance = 1'b0;
    endcase
  end

  assign rise = advance && !ph;

  always_ff @(posedge emu_clk_2x or negedge emu_rst_n) begin
    if (!emu_rst_n) begin
      ph            <= 1'b0;
      emu_cycle_cnt <= '0;
    end else begin
      if (advance) ph <= ~ph;
      if (rise)    emu_cycle_cnt <= emu_cycle_cnt + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < n; k++) begin : g_chan
    emu_clk_chan #(
      .DIV_W(DIV_W)
    ) u_chan (
      .emu_clk_2x (emu_clk_2x),
      .emu_rst_n  (emu_rst_n),
      .rise_en    (rise),
      .mode       (chan_mode_t'(chan_mode[k])),
      .clk_val    (clk_vals[k]),
      .div_ratio  (div_ratio[k]),
      .clk_out    (clks_q[k])
    );
  end

`ifdef EMU_CLK_BUFG_EN
  BUFG u_emu_clk_bufg (
    .I (ph),
    .O (emu_clk)
  );
  for (genvar k = 0; k < n; k++) begin : g_clk_bufg
    BUFG u_bufg (
      .I (clks_q[k]),
      .O (clks[k])
    );
  end
`else
  assign emu_clk = ph;
  assign clks    = clks_q;
`endif

endmodule

// File: tb/tb_gen_emu_clks_ctrl.sv
// Self-checking bench for gen_emu_clks_ctrl: free run, pause, step, dividers,
// async reset during a step and counter wrap on a narrow instance.
module tb_gen_emu_clks_ctrl;

  localparam int N     = 2;
  localparam int DIV_W = 8;
  localparam int CNT_W = 32;

  logic                    emu_clk_2x = 1'b0;
  logic                    emu_rst_n;
  logic                    pause_req;
  logic                    step_req;
  logic [N-1:0]            clk_vals;
  logic [N-1:0]            chan_mode;
  logic [N-1:0][DIV_W-1:0] div_ratio;
  logic                    emu_clk;
  logic                    pause_ack;
  logic [N-1:0]            clks;
  logic [CNT_W-1:0]        emu_cycle_cnt;

  logic                    rst_w_n;
  logic                    emu_clk_w;
  logic                    ack_w;
  logic [0:0]              clks_w;
  logic [3:0]              cnt_w;

  typedef struct packed {
    logic             ph;
    logic             ack;
    logic [N-1:0]     clks;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  typedef struct {
    int unsigned ratio;
    int          rises;
    int          period;
    int          offset;
  } seg_t;

  exp_t             sb[$];
  logic [3:0]       sb_w[$];
  int               checks = 0;
  int               errors = 0;
  logic             exp_ph;
  logic             exp_ack;
  logic [N-1:0]     exp_clks;
  logic [CNT_W-1:0] exp_cnt;

  always #5 emu_clk_2x = ~emu_clk_2x;

  gen_emu_clks_ctrl #(
    .n(N), .DIV_W(DIV_W), .CNT_W(CNT_W)
  ) dut (
    .emu_clk_2x    (emu_clk_2x),
    .emu_rst_n     (emu_rst_n),
    .emu_clk       (emu_clk),
    .pause_req     (pause_req),
    .pause_ack     (pause_ack),
    .step_req      (step_req),
    .clk_vals      (clk_vals),
    .chan_mode     (chan_mode),
    .div_ratio     (div_ratio),
    .clks          (clks),
    .emu_cycle_cnt (emu_cycle_cnt)
  );

  gen_emu_clks_ctrl #(
    .n(1), .DIV_W(DIV_W), .CNT_W(4)
  ) dut_w (
    .emu_clk_2x    (emu_clk_2x),
    .emu_rst_n     (rst_w_n),
    .emu_clk       (emu_clk_w),
    .pause_req     (1'b0),
    .pause_ack     (ack_w),
    .step_req      (1'b0),
    .clk_vals      (1'b1),
    .chan_mode     (1'b0),
    .div_ratio     (8'd0),
    .clks          (clks_w),
    .emu_cycle_cnt (cnt_w)
  );

  function automatic exp_t observed();
    return {emu_clk, pause_ack, clks, emu_cycle_cnt};
  endfunction

  function automatic exp_t expected_now();
    return {exp_ph, exp_ack, exp_clks, exp_cnt};
  endfunction

  task automatic test_reset();
    exp_t got;
    emu_rst_n = 1'b0;
    rst_w_n   = 1'b0;
    pause_req = 1'b0;
    step_req  = 1'b0;
    clk_vals  = '0;
    chan_mode = '0;
    div_ratio = '0;
    repeat (2) @(negedge emu_clk_2x);
    got = observed();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h expected %h", got, exp_t'(0));
    end
    emu_rst_n = 1'b1;
    exp_ph = 1'b0; exp_ack = 1'b0; exp_clks = '0; exp_cnt = '0;
  endtask

  task automatic test_free_run();
    exp_t got, exp;
    for (int e = 0; e < 20; e++) begin
      if (!exp_ph) begin
        clk_vals = ~clk_vals;
        exp_clks = clk_vals;
        exp_cnt++;
      end
      exp_ph = ~exp_ph;
      sb.push_back(expected_now());
      @(negedge emu_clk_2x);
      exp = sb.pop_front();
      got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL free_run edge %0d: got %h expected %h", e, got, exp);
      end
    end
    checks++;
    if (emu_cycle_cnt !== 32'd10) begin
      errors++;
      $display("[TB] FAIL free_run_count: got %0d expected 10", emu_cycle_cnt);
    end
  endtask

  task automatic test_pause();
    exp_t got, exp;
    // one rise so emu_clk is high when pause is requested
    clk_vals = ~clk_vals; exp_clks = clk_vals; exp_cnt++; exp_ph = 1'b1;
    sb.push_back(expected_now());
    @(negedge emu_clk_2x);
    pause_req = 1'b1;
    exp_ph = 1'b0;
    sb.push_back(expected_now());
    exp_ack = 1'b1;
    sb.push_back(expected_now());
    for (int e = 0; e < 53; e++) begin
      if (e > 0) begin
        if (e > 2) sb.push_back(expected_now());
        @(negedge emu_clk_2x);
      end
      exp = sb.pop_front();
      got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL pause edge %0d: got %h expected %h", e, got, exp);
      end
      clk_vals = ~clk_vals;
    end
  endtask

  task automatic test_step();
    exp_t got, exp;
    step_req = 1'b1;
    exp_ack = 1'b0;
    sb.push_back(expected_now());
    for (int e = 0; e < 6; e++) begin
      @(negedge emu_clk_2x);
      exp = sb.pop_front();
      got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL step edge %0d: got %h expected %h", e, got, exp);
      end
      step_req = 1'b0;
      if (e == 0) begin
        clk_vals = ~clk_vals; exp_clks = clk_vals; exp_cnt++; exp_ph = 1'b1;
      end else if (e == 1) begin
        exp_ph = 1'b0; exp_ack = 1'b1;
      end else begin
        clk_vals = ~clk_vals;
      end
      sb.push_back(expected_now());
    end
    sb.delete();
  endtask

  task automatic test_divider();
    exp_t got, exp;
    seg_t segs[4];
    segs[0] = '{3, 12, 3, 0};
    segs[1] = '{0, 6, 1, 0};
    segs[2] = '{10, 7, 0, 0};
    segs[3] = '{2, 8, 2, 1};
    chan_mode = 2'b01;
    div_ratio[0] = 8'd3;
    pause_req = 1'b0;
    exp_ack = 1'b0;
    sb.push_back(expected_now());
    @(negedge emu_clk_2x);
    exp = sb.pop_front();
    got = observed();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL release: got %h expected %h", got, exp);
    end
    for (int s = 0; s < 4; s++) begin
      div_ratio[0] = DIV_W'(segs[s].ratio);
      for (int r = 1; r <= segs[s].rises; r++) begin
        for (int h = 0; h < 2; h++) begin
          if (h == 0) begin
            clk_vals[1] = ~clk_vals[1];
            exp_clks[1] = clk_vals[1];
            if (segs[s].period != 0 && (r + segs[s].offset) % segs[s].period == 0)
              exp_clks[0] = ~exp_clks[0];
            exp_cnt++;
          end
          exp_ph = ~exp_ph;
          sb.push_back(expected_now());
          @(negedge emu_clk_2x);
          exp = sb.pop_front();
          got = observed();
          checks++;
          if (got !== exp) begin
            errors++;
            $display("[TB] FAIL divider seg %0d rise %0d half %0d: got %h expected %h",
                     s, r, h, got, exp);
          end
        end
      end
    end
  endtask

  task automatic test_reset_in_step();
    exp_t got, exp;
    chan_mode = '0;
    clk_vals  = 2'b10;
    pause_req = 1'b1;
    @(negedge emu_clk_2x);
    step_req = 1'b1;
    @(negedge emu_clk_2x);
    step_req = 1'b0;
    @(negedge emu_clk_2x);
    checks++;
    if (emu_clk !== 1'b1 || pause_ack !== 1'b0) begin
      errors++;
      $display("[TB] FAIL step_mid: got emu_clk %b ack %b expected 1 0", emu_clk, pause_ack);
    end
    #2 emu_rst_n = 1'b0;
    #1 got = observed();
    checks++;
    if (got !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h expected %h", got, exp_t'(0));
    end
    pause_req = 1'b0;
    emu_rst_n = 1'b1;
    exp_ph = 1'b0; exp_ack = 1'b0; exp_clks = '0; exp_cnt = '0;
    for (int e = 0; e < 4; e++) begin
      if (!exp_ph) begin
        exp_clks = clk_vals;
        exp_cnt++;
      end
      exp_ph = ~exp_ph;
      sb.push_back(expected_now());
      @(negedge emu_clk_2x);
      exp = sb.pop_front();
      got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("[TB] FAIL post_reset edge %0d: got %h expected %h", e, got, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_w;
    logic [3:0] model_w;
    model_w = 4'd0;
    rst_w_n = 1'b1;
    for (int e = 0; e < 34; e++) begin
      if (e % 2 == 0) model_w = model_w + 4'd1;
      sb_w.push_back(model_w);
      @(negedge emu_clk_2x);
      exp_w = sb_w.pop_front();
      checks++;
      if (cnt_w !== exp_w) begin
        errors++;
        $display("[TB] FAIL wrap edge %0d: got %0d expected %0d", e, cnt_w, exp_w);
      end
      if (e == 31) begin
        checks++;
        if (cnt_w !== 4'd0) begin
          errors++;
          $display("[TB] FAIL wrap_zero: got %0d expected 0", cnt_w);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_pause();
    test_step();
    test_divider();
    test_reset_in_step();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
